// File: rtl/fma_pkg.sv
// fma_pkg: shared FP format constants, rounding-mode codes and drain FSM states
// for the fpfma datapath and its issue arbiter.
package fma_pkg;
   localparam int WIDTH     = 32;
   localparam int EXP_WIDTH = 8;
   localparam int SIG_WIDTH = 23;

   localparam logic [1:0] RND_RZ  = 2'b00;
   localparam logic [1:0] RND_RN  = 2'b01;
   localparam logic [1:0] RND_RNE = 2'b10;

   typedef enum logic [1:0] {ST_RUN, ST_DRAINING, ST_DRAINED} state_t;
endpackage

// File: rtl/fpfma.sv
// fpfma: combinational single-precision fused multiply-add a*b+c with one rounding
// (RZ, RN ties-away, RNE), gradual underflow, IEEE specials; NaNs return the default qNaN.
module fpfma
   import fma_pkg::*;
(
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [1:0]       rnd,
   output logic [WIDTH-1:0] result
);
   logic [EXP_WIDTH-1:0] xa, xb, xc;
   logic [23:0] ma, mb, mc, m24;
   logic [47:0] mp;
   logic signed [10:0] ea, eb, ec, ep, ebig, dd, e, e1, shamt, nsh;
   logic [51:0] big, sml, al;
   logic [103:0] sh;
   logic [52:0] mag, diff, norm;
   logic [105:0] tmp;
   logic [30:0] r31;
   logic [7:0] ex;
   logic [5:0] d, lz, r;
   logic sp, pz, cz, pinf, inf_c, nan_in, sel_c, sbig, ssml, rs, g, st, inc, ovf;

   assign xa = a[30:23];
   assign xb = b[30:23];
   assign xc = c[30:23];
   assign ma = {|xa, a[22:0]};
   assign mb = {|xb, b[22:0]};
   assign mc = {|xc, c[22:0]};
   assign ea = $signed({3'b0, (|xa) ? xa : 8'd1});
   assign eb = $signed({3'b0, (|xb) ? xb : 8'd1});
   assign ec = $signed({3'b0, (|xc) ? xc : 8'd1});

   always_comb begin
      sp = a[31] ^ b[31];
      pz = ~|a[30:0] | ~|b[30:0];
      cz = ~|c[30:0];
      pinf = (&xa & ~|a[22:0]) | (&xb & ~|b[22:0]);
      inf_c = &xc & ~|c[22:0];
      nan_in = (&xa & |a[22:0]) | (&xb & |b[22:0]) | (&xc & |c[22:0]);
      mp = {24'b0, ma} * {24'b0, mb};
      ep = ea + eb - 11'sd127;
      // Both operands share a binary point at bit 49; a zero addend never leads.
      sel_c = ~cz & (pz | (ec > ep));
      big = sel_c ? {2'b0, mc, 26'b0} : {1'b0, mp, 3'b0};
      sml = sel_c ? {1'b0, mp, 3'b0} : {2'b0, mc, 26'b0};
      ebig = sel_c ? ec : ep;
      sbig = sel_c ? c[31] : sp;
      ssml = sel_c ? sp : c[31];
      dd = sel_c ? ec - ep : ep - ec;
      d = (dd > 11'sd63) ? 6'd63 : dd[5:0];
      sh = {sml, 52'b0} >> d;
      al = {sh[103:53], sh[52] | (|sh[51:0])};
      diff = {1'b0, big} - {1'b0, al};
      mag = (sbig == ssml) ? {1'b0, big} + {1'b0, al} : diff[52] ? -diff : diff;
      rs = (sbig != ssml && diff[52]) ? ~sbig : sbig;
      lz = 6'd53;
      for (int i = 0; i < 53; i++) if (mag[i]) lz = 6'(52 - i);
      e = ebig + 11'sd3 - $signed({5'b0, lz});
      // Results below the normal range stop normalising at exponent 1 (subnormal).
      shamt = (e < 11'sd1) ? ebig + 11'sd2 : $signed({5'b0, lz});
      e1 = (e < 11'sd1) ? 11'sd1 : e;
      nsh = -shamt;
      r = (nsh > 11'sd63) ? 6'd63 : nsh[5:0];
      tmp = {mag, 53'b0} >> r;
      norm = (shamt >= 11'sd0) ? mag << shamt[5:0] : {tmp[105:54], tmp[53] | (|tmp[52:0])};
      m24 = norm[52:29];
      g = norm[28];
      st = |norm[27:0];
      inc = (rnd == RND_RZ) ? 1'b0 : (rnd == RND_RN) ? g : g & (st | m24[0]);
      ex = m24[23] ? e1[7:0] : 8'd0;
      r31 = {ex, m24[22:0]} + {30'b0, inc};
      ovf = (e1 > 11'sd254) | (&r31[30:23]);
      result = ovf ? ((rnd == RND_RZ) ? {rs, 31'h7F7FFFFF} : {rs, 31'h7F800000}) : {rs, r31};
      if (mag == 53'b0) result = {sbig & ssml, 31'b0};
      if (inf_c) result = c;
      if (pinf) result = {sp, 31'h7F800000};
      if (nan_in | (pinf & pz) | (pinf & inf_c & (sp != c[31]))) result = 32'h7FC00000;
   end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick among req, searching upward from ptr+1 and wrapping.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int ID_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [ID_W-1:0] ptr,
   output logic [NREQ-1:0] grant,
   output logic [ID_W-1:0] idx
);
   always_comb begin
      int i;
      i = 0;
      grant = '0;
      idx = '0;
      // Walk from farthest to nearest so the nearest requester wins.
      for (int k = NREQ; k >= 1; k--) begin
         i = (int'(ptr) + k) % NREQ;
         if (req[i]) begin
            grant = '0;
            grant[i] = 1'b1;
            idx = ID_W'(i);
         end
      end
   end
endmodule

// File: rtl/fma_issue_arbiter.sv
// fma_issue_arbiter: round-robin issue of NREQ requesters into one shared fpfma,
// with operand stage, PIPE_STAGES result stages, whole-pipe stall and a drain FSM.
module fma_issue_arbiter
   import fma_pkg::*;
#(
   parameter int NREQ        = 4,
   parameter int ID_W        = $clog2(NREQ),
   parameter int PIPE_STAGES = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   input  logic [NREQ*WIDTH-1:0] req_c,
   input  logic [NREQ*2-1:0]     req_rnd,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [WIDTH-1:0]      rsp_result,
   output logic [ID_W-1:0]       rsp_id,
   input  logic                  drain_req,
   output logic                  drained
);
   state_t state, state_nx;
   logic [ID_W-1:0] ptr, gidx, id0;
   logic [NREQ-1:0] grant;
   logic [WIDTH-1:0] a0, b0, c0, fma_out;
   logic [1:0] rnd0;
   logic v0, stall, accept, empty;
   logic [PIPE_STAGES:1] sv;
   logic [WIDTH-1:0] sres [1:PIPE_STAGES];
   logic [ID_W-1:0] sid [1:PIPE_STAGES];

   rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
      .req(req_valid), .ptr(ptr), .grant(grant), .idx(gidx)
   );

   fpfma u_fma (.a(a0), .b(b0), .c(c0), .rnd(rnd0), .result(fma_out));

   assign rsp_valid = sv[PIPE_STAGES];
   assign rsp_result = sres[PIPE_STAGES];
   assign rsp_id = sid[PIPE_STAGES];
   assign stall = rsp_valid & ~rsp_ready;
   assign req_ready = grant & {NREQ{rst_n & ~stall & (state == ST_RUN) & ~drain_req}};
   assign accept = |(req_valid & req_ready);
   assign empty = ~v0 & ~|sv;
   assign drained = state == ST_DRAINED;

   always_comb begin
      state_nx = state;
      state_nx = (state == ST_RUN) ? (drain_req ? ST_DRAINING : ST_RUN) :
                 (state == ST_DRAINING) ? (~drain_req ? ST_RUN : empty ? ST_DRAINED : ST_DRAINING) :
                 (drain_req ? ST_DRAINED : ST_RUN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_RUN;
         ptr <= ID_W'(NREQ - 1);
         v0 <= 1'b0;
         a0 <= '0;
         b0 <= '0;
         c0 <= '0;
         rnd0 <= '0;
         id0 <= '0;
         sv <= '0;
         for (int k = 1; k <= PIPE_STAGES; k++) begin
            sres[k] <= '0;
            sid[k] <= '0;
         end
      end else begin
         state <= state_nx;
         if (accept) ptr <= gidx;
         if (!stall) begin
            v0 <= accept;
            if (accept) begin
               a0 <= req_a[gidx*WIDTH +: WIDTH];
               b0 <= req_b[gidx*WIDTH +: WIDTH];
               c0 <= req_c[gidx*WIDTH +: WIDTH];
               rnd0 <= req_rnd[gidx*2 +: 2];
               id0 <= gidx;
            end
            sv[1] <= v0;
            sres[1] <= fma_out;
            sid[1] <= id0;
            for (int k = 2; k <= PIPE_STAGES; k++) begin
               sv[k] <= sv[k-1];
               sres[k] <= sres[k-1];
               sid[k] <= sid[k-1];
            end
         end
      end
   end
endmodule
